prio_enc_arbiter: RTL and testbench
===================================

# prio_enc_arbiter

Parametrised, registered priority encoder/arbiter: N request lines in, one registered winner index out with a valid/ready handshake. Fixed priority (highest index wins) or runtime-selectable round-robin with a rotating pointer. Sits between request sources and a single consumer. The grant is held stable until the consumer accepts it, so a slow consumer never sees the index change under it.

## Interface
- `N`, default 8: number of request lines, ≥ 2.
- `W`, default $clog2(N): index width, derived; do not override.
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: reset, asynchronous assert, active-low.
- `req`, input, N: request vector, level-sensitive, bit i = requester i.
- `rr_en`, input, 1: 0 = fixed priority, 1 = round-robin; sampled only at evaluation edges.
- `out_valid`, output, 1: registered grant present.
- `out_ready`, input, 1: consumer accepts the grant when high with `out_valid`.
- `out_idx`, output, W: binary index of the granted requester.
- `out_onehot`, output, N: one-hot form of `out_idx`; all zeros when `out_valid`=0.
- `ptr`, output, W: current round-robin top-priority index, for debug and verification.

## Operation
- States:
  - IDLE (`out_valid`=0).
  - HOLD (`out_valid`=1).
- Evaluation happens at a rising edge in either of two cases:
  - state is IDLE;
  - state is HOLD and a handshake occurs (`out_valid` & `out_ready`).
- Winner selection:
  - Fixed mode: the highest set index of `req`.
  - RR mode: the first set bit found searching downward from `ptr`, wrapping from 0 to N-1.
- At an evaluation edge:
  - If `req`≠0: load the winner into `out_idx` and `out_onehot`, set `out_valid`=1, go to HOLD.
  - If `req`=0: set `out_valid`=0, go to IDLE.
  - `out_idx` keeps its last value when invalid. Never drive X.
- In HOLD without a handshake:
  - All outputs are frozen.
  - Changes to `req` (including dropping the granted bit) and to `rr_en` are ignored.
- Pointer update: on every handshake with granted index k, `ptr` ← (k==0 ? N-1 : k-1).
  - Applies in both modes, so enabling RR starts from a sane point.
  - The pointer update and the next evaluation in the same edge use the **old** `ptr`, then register the new one.
  - Exception: the new winner is computed with `ptr` = updated value (combinational next-ptr). This makes back-to-back RR fair: the just-served index k gets lowest priority immediately.
- Width rules:
  - `ptr` and `out_idx` always lie in 0..N-1.
  - For non-power-of-2 N, the wrap is explicit (N-1), not a natural overflow.

## Timing
- Reset values:
  - `out_valid`=0, `out_idx`=0, `out_onehot`=0, `ptr`=N-1, state IDLE.
  - Reset is asynchronous and may hit mid-HOLD. The pending grant is dropped with no handshake.
- Latency: `req` sampled at edge t yields `out_valid` high after edge t (visible in cycle t+1). There is no combinational path from `req` to any output.
- Throughput:
  - One grant per cycle when `out_ready` is held high and `req`≠0.
  - There is no bubble between consecutive grants.
- `out_ready` while `out_valid`=0 has no effect (no pointer change).
- `rr_en` toggling takes effect at the next evaluation edge only.

## Structure
- Shared package `prio_enc_pkg`: mode encoding constants (MODE_FIXED=0, MODE_RR=1) and the state enum (IDLE, HOLD).
- One sub-module, `prio_find_hi`: a parametrised combinational highest-set-bit finder returning {found, idx}.
  - The top instantiates it twice for RR: one on `req` masked to indices ≤ next-ptr, one on unmasked `req` as the wrap fallback.
  - In fixed mode only the unmasked instance is used.
- The top holds the state register, pointer register, one-hot decode and handshake logic.

## Test plan
- Reset and idle:
  - Stimulus: assert `rst_n`=0 mid-HOLD (`out_idx`=5).
  - Required: `out_valid`=0 and `ptr`=7 immediately (asynchronous). After release with `req`=0, the outputs stay invalid.
- Fixed priority, N=8, rr_en=0:
  - Stimulus: `req`=8'b0010_1100, `out_ready`=1.
  - Required: grants 5, 5, 5… every cycle. Then `req`=8'b0000_0001 → `out_idx`=0, `out_onehot`=8'h01.
- Hold stability:
  - Stimulus: grant 3 with `out_ready`=0 for 4 cycles while `req` changes to 8'h80.
  - Required: `out_idx` stays 3. On `out_ready`=1, the next grant is 7.
- Round-robin fairness, rr_en=1:
  - Stimulus: `req`=8'hFF held, `out_ready`=1.
  - Required: grant sequence 7, 6, 5, …, 0, 7 with no bubbles; `ptr` tracks k-1.
- RR wrap with sparse requests:
  - Stimulus: `ptr`=1, `req`=8'b1000_0100.
  - Required: grant 7, then 2, then 7. Dropping `req` to 0 at the handshake → `out_valid`=0 next cycle.
- Non-power-of-2, N=5:
  - Stimulus: RR with `req`=5'b10001.
  - Required: grants alternate 4, 0, 4. `ptr` after granting 0 is 4, never 5–7.

Source files
------------

// File: rtl/prio_enc_pkg.sv
// Shared definitions for the priority encoder / arbiter: mode encoding and
// the two-state grant FSM.
package prio_enc_pkg;

  // Meaning of the rr_en input
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // IDLE: no grant presented; HOLD: a grant is presented and frozen
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage : prio_enc_pkg

// File: rtl/prio_find_hi.sv
// Combinational highest-set-bit finder. found_o is 0 and idx_o is 0 when no
// bit of vec_i is set, so the result is never X.
module prio_find_hi #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec_i,
  output logic         found_o,
  output logic [W-1:0] idx_o
);

  // Scan upward so the last (highest) set bit overrides earlier ones
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = 0; i < N; i++) begin
      idx_o   = vec_i[i] ? W'(i) : idx_o;
      found_o = found_o | vec_i[i];
    end
  end

endmodule : prio_find_hi

// File: rtl/prio_enc_arbiter.sv
// Registered priority encoder / arbiter with valid/ready output.
// Fixed mode grants the highest requesting index; round-robin mode searches
// downward from the pointer with wrap. A presented grant is frozen until the
// consumer accepts it. The winner evaluated in a handshake cycle already uses
// the post-handshake pointer, so the index just served drops to lowest
// priority immediately.
module prio_enc_arbiter
  import prio_enc_pkg::*;
#(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         rr_en,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_onehot,
  output logic [W-1:0] ptr
);

  state_e       state_q, state_d;
  logic [W-1:0] idx_q, idx_d;
  logic [N-1:0] onehot_q, onehot_d;
  logic [W-1:0] ptr_q, ptr_d;

  logic         handshake_s;
  logic         eval_s;
  logic [N-1:0] mask_s;
  logic [N-1:0] masked_req_s;
  logic         m_found_s;
  logic [W-1:0] m_idx_s;
  logic         f_found_s;
  logic [W-1:0] f_idx_s;
  logic [W-1:0] win_idx_s;
  logic [N-1:0] win_onehot_s;

  // A handshake can only happen while a grant is being presented
  assign handshake_s = (state_q == HOLD) && out_ready;

  // Next pointer: one below the granted index, wrapping explicitly to N-1
  always_comb begin
    ptr_d = ptr_q;
    if (handshake_s) begin
      ptr_d = (idx_q == '0) ? W'(N - 1) : (idx_q - W'(1));
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Round-robin window: indices at or below the next pointer
  always_comb begin
    mask_s = '0;
    for (int i = 0; i < N; i++) begin
      mask_s[i] = (W'(i) <= ptr_d);
    end
  end

  assign masked_req_s = req & mask_s;

  // Search inside the round-robin window
  prio_find_hi #(
    .N(N),
    .W(W)
  ) u_find_masked (
    .vec_i  (masked_req_s),
    .found_o(m_found_s),
    .idx_o  (m_idx_s)
  );

  // Unmasked search: fixed-priority winner and round-robin wrap fallback
  prio_find_hi #(
    .N(N),
    .W(W)
  ) u_find_full (
    .vec_i  (req),
    .found_o(f_found_s),
    .idx_o  (f_idx_s)
  );

  // Pick the winner for the selected mode
  always_comb begin
    win_idx_s = f_idx_s;
    if ((rr_en == MODE_RR) && m_found_s) begin
      win_idx_s = m_idx_s;
    end else begin
      win_idx_s = f_idx_s;
    end
  end

  // One-hot decode of the winner, compared per lane to stay in range for any N
  always_comb begin
    win_onehot_s = '0;
    for (int i = 0; i < N; i++) begin
      win_onehot_s[i] = (win_idx_s == W'(i));
    end
  end

  // Evaluation edges: whenever idle, or when the presented grant is accepted
  always_comb begin
    eval_s = 1'b0;
    case (state_q)
      IDLE:    eval_s = 1'b1;
      HOLD:    eval_s = out_ready;
      default: eval_s = 1'b1;
    endcase
  end

  // Next-state and next-output logic; outputs frozen outside evaluation edges
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    onehot_d = onehot_q;
    if (eval_s) begin
      if (f_found_s) begin
        state_d  = HOLD;
        idx_d    = win_idx_s;
        onehot_d = win_onehot_s;
      end else begin
        state_d  = IDLE;
        idx_d    = idx_q;
        onehot_d = '0;
      end
    end else begin
      state_d  = state_q;
      idx_d    = idx_q;
      onehot_d = onehot_q;
    end
  end

  // State, grant and pointer registers; reset drops any pending grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      onehot_q <= '0;
      ptr_q    <= W'(N - 1);
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      onehot_q <= onehot_d;
      ptr_q    <= ptr_d;
    end
  end

  assign out_valid  = (state_q == HOLD);
  assign out_idx    = idx_q;
  assign out_onehot = onehot_q;
  assign ptr        = ptr_q;

endmodule : prio_enc_arbiter

// File: tb/tb_prio_enc_arbiter.sv
// Scoreboard bench for prio_enc_arbiter: an N=8 and an N=5 instance.
// Stimulus pushes the hand-computed index of every new grant; a monitor pops
// and compares at each accepted handshake. State checks (reset, hold, pointer)
// are made directly after the relevant edges.
module tb_prio_enc_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] req8;
  logic       rr8, rdy8, v8;
  logic [2:0] idx8, ptr8;
  logic [7:0] oh8;
  logic [4:0] req5;
  logic       rr5, rdy5, v5;
  logic [2:0] idx5, ptr5;
  logic [4:0] oh5;

  int n_chk  = 0;
  int n_fail = 0;
  int q8[$];
  int q5[$];

  int rr_grant[9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
  int rr_ptr[9]   = '{7, 6, 5, 4, 3, 2, 1, 0, 7};

  prio_enc_arbiter #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .req(req8), .rr_en(rr8),
    .out_valid(v8), .out_ready(rdy8), .out_idx(idx8),
    .out_onehot(oh8), .ptr(ptr8)
  );

  prio_enc_arbiter #(.N(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .req(req5), .rr_en(rr5),
    .out_valid(v5), .out_ready(rdy5), .out_idx(idx5),
    .out_onehot(oh5), .ptr(ptr5)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle of N=8 stimulus; push_idx >= 0 is the grant expected after the edge
  task automatic step8(input logic [7:0] r, input logic rr, input logic rdy, input int push_idx);
    req8 = r; rr8 = rr; rdy8 = rdy;
    if (push_idx >= 0) q8.push_back(push_idx);
    @(posedge clk); #1;
  endtask

  task automatic step5(input logic [4:0] r, input logic rr, input logic rdy, input int push_idx);
    req5 = r; rr5 = rr; rdy5 = rdy;
    if (push_idx >= 0) q5.push_back(push_idx);
    @(posedge clk); #1;
  endtask

  // Monitor for the N=8 instance: compare each accepted grant
  always @(negedge clk) begin
    int e;
    if (rst_n && v8 && rdy8) begin
      if (q8.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL grant8_unexpected: got idx %0d, expected no grant", idx8);
      end else begin
        e = q8.pop_front();
        chk("grant8_idx", int'(idx8), e);
        chk("grant8_onehot", int'(oh8), 1 << e);
      end
    end
  end

  // Monitor for the N=5 instance
  always @(negedge clk) begin
    int e;
    if (rst_n && v5 && rdy5) begin
      if (q5.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL grant5_unexpected: got idx %0d, expected no grant", idx5);
      end else begin
        e = q5.pop_front();
        chk("grant5_idx", int'(idx5), e);
        chk("grant5_onehot", int'(oh5), 1 << e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req8 = 8'h00; rr8 = 1'b0; rdy8 = 1'b0;
    req5 = 5'h00; rr5 = 1'b0; rdy5 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state
    chk("rst_valid8", int'(v8), 0);
    chk("rst_idx8", int'(idx8), 0);
    chk("rst_onehot8", int'(oh8), 0);
    chk("rst_ptr8", int'(ptr8), 7);
    chk("rst_valid5", int'(v5), 0);
    chk("rst_ptr5", int'(ptr5), 4);

    // Asynchronous reset in the middle of a held grant
    step8(8'h2C, 1'b0, 1'b0, 5);
    chk("pre_reset_valid", int'(v8), 1);
    chk("pre_reset_idx", int'(idx8), 5);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", int'(v8), 0);
    chk("async_rst_ptr", int'(ptr8), 7);
    chk("async_rst_idx", int'(idx8), 0);
    chk("async_rst_onehot", int'(oh8), 0);
    q8.delete();
    req8 = 8'h00;
    @(posedge clk); #1 rst_n = 1'b1;
    step8(8'h00, 1'b0, 1'b1, -1);
    chk("idle_after_rst_a", int'(v8), 0);
    step8(8'h00, 1'b0, 1'b1, -1);
    chk("idle_after_rst_b", int'(v8), 0);
    chk("idle_ptr_unchanged", int'(ptr8), 7);

    // Fixed priority
    step8(8'h2C, 1'b0, 1'b1, 5);
    step8(8'h2C, 1'b0, 1'b1, 5);
    step8(8'h2C, 1'b0, 1'b1, 5);
    step8(8'h01, 1'b0, 1'b1, 0);
    chk("fixed_idx0_onehot", int'(oh8), 8'h01);
    step8(8'h08, 1'b0, 1'b1, 3);

    // Hold stability: grant 3 frozen while req moves to 8'h80
    for (int i = 0; i < 4; i++) begin
      step8(8'h80, 1'b0, 1'b0, -1);
      chk("hold_idx", int'(idx8), 3);
      chk("hold_valid", int'(v8), 1);
    end
    step8(8'h80, 1'b0, 1'b1, 7);
    step8(8'h00, 1'b0, 1'b1, -1);
    chk("drop_valid", int'(v8), 0);
    chk("drop_onehot", int'(oh8), 0);
    chk("drop_idx_kept", int'(idx8), 7);
    chk("drop_ptr", int'(ptr8), 6);

    // Round-robin fairness from a fresh pointer
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    chk("rr_start_ptr", int'(ptr8), 7);
    for (int j = 0; j < 9; j++) begin
      step8(8'hFF, 1'b1, 1'b1, rr_grant[j]);
      chk("rr_no_bubble", int'(v8), 1);
      chk("rr_ptr", int'(ptr8), rr_ptr[j]);
    end

    // Round-robin wrap with sparse requests
    step8(8'h04, 1'b1, 1'b1, 2);
    chk("wrap_ptr_a", int'(ptr8), 6);
    step8(8'h84, 1'b1, 1'b1, 7);
    chk("wrap_ptr_b", int'(ptr8), 1);
    step8(8'h84, 1'b1, 1'b1, 2);
    chk("wrap_ptr_c", int'(ptr8), 6);
    step8(8'h84, 1'b1, 1'b1, 7);
    chk("wrap_ptr_d", int'(ptr8), 1);
    step8(8'h00, 1'b1, 1'b1, -1);
    chk("wrap_drop_valid", int'(v8), 0);
    chk("wrap_drop_ptr", int'(ptr8), 6);
    step8(8'h00, 1'b1, 1'b1, -1);
    chk("idle_ready_ptr", int'(ptr8), 6);

    // Non-power-of-2 instance, round-robin
    step5(5'b10001, 1'b1, 1'b1, 4);
    chk("n5_ptr_a", int'(ptr5), 4);
    step5(5'b10001, 1'b1, 1'b1, 0);
    chk("n5_ptr_b", int'(ptr5), 3);
    step5(5'b10001, 1'b1, 1'b1, 4);
    chk("n5_ptr_after_0", int'(ptr5), 4);
    step5(5'b10001, 1'b1, 1'b1, 0);
    chk("n5_ptr_c", int'(ptr5), 3);
    step5(5'b00000, 1'b1, 1'b1, -1);
    chk("n5_drop_valid", int'(v5), 0);
    chk("n5_ptr_wrap", int'(ptr5), 4);

    // Every expected grant must have been observed
    chk("q8_drained", q8.size(), 0);
    chk("q5_drained", q5.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_prio_enc_arbiter
